matrix_stream_out: RTL and testbench
====================================

// Module: matrix_stream_out
// PURPOSE
//  Sits at the other end of the per-frame normal-equation accumulator and carries its results downstream.
//  - Capture: on the accumulator's frame-end pulse, snapshots the 21 lower-triangle entries of the 6x6
//    Hessian and the 6 gradient entries into a shadow bank.
//  - Stream: sends those 27 words one per beat over a valid/ready interface, with index and last-beat
//    tag, to the pose solver / host reader.
//  - Decoupling: the snapshot lets the accumulator restart on the next frame at once.
// PARAMETERS
//  DATA_BW    64   width of each matrix/vector word (= accumulator output width)
//  NUM_MAT    21   lower-triangle entries captured (fixed for 6x6; not to be overridden)
//  NUM_VEC    6    vector entries captured (fixed)
// PORTS
//  i_clk        in   1            clock
//  i_rst        in   1            asynchronous reset, active-high
//  i_frame_end  in   1            1-cycle pulse; i_mat/i_vec valid in this same cycle
//  i_mat        in   21*DATA_BW   slice k = entry k of order 00,10,20,30,40,50,11,21,31,41,51,22,32,42,52,33,43,53,44,54,55
//  i_vec        in   6*DATA_BW    slice k = Vec_k
//  o_valid      out  1            output word valid
//  i_ready      in   1            downstream accepts word when o_valid&&i_ready
//  o_data       out  DATA_BW      current word
//  o_idx        out  5            word index 0..26 (0..20 matrix, 21..26 vector)
//  o_last       out  1            high with o_valid when o_idx==26
//  o_busy       out  1            snapshot held / stream in progress
//  o_drop       out  1            1-cycle pulse: a frame_end was rejected
// BEHAVIOUR
//  Reset values
//  - o_valid=0, o_data=0, o_idx=0, o_last=0, o_busy=0, o_drop=0.
//  - Shadow bank cleared to 0; FSM in IDLE.
//  - Reset is async assert; a reset mid-stream aborts the stream immediately.
//  - After reset, no further beats are sent until the next i_frame_end.
//  FSM states: IDLE, SEND.
//  - IDLE + i_frame_end: latch i_mat/i_vec into shadow, idx<=0, go SEND.
//    o_valid=1 and o_data=word0 on the next cycle (1-cycle latency).
//  - SEND: o_valid=1; o_data = shadow[idx]; o_busy=1.
//  - SEND, handshake with idx<26: idx<=idx+1; the next word is presented the following cycle.
//    Full throughput: 27 beats in 27 cycles when i_ready is held high.
//  - SEND, handshake with idx==26 (o_last): go IDLE, o_valid<=0, o_idx<=0.
//  Handshake rules
//  - While o_valid && !i_ready, o_data/o_idx/o_last are held stable.
//  - o_valid is never withdrawn before its handshake, except by reset.
//  - i_ready is ignored while o_valid=0.
//  Boundary conditions
//  - i_frame_end in SEND, not on the last handshake: ignored. Shadow is unchanged and o_drop pulses next cycle.
//  - i_frame_end in the same cycle as the idx==26 handshake: accepted.
//    Shadow is recaptured, idx<=0, stay SEND, o_valid stays 1 with no gap. No o_drop.
//  - i_frame_end in the same cycle as the rising edge of i_rst: reset wins, nothing captured.
//  Arithmetic / width rules
//  - Words are passed through bit-exact; no sign handling or arithmetic.
//  - idx is a 5-bit counter that never exceeds 26 and does not wrap.
//  - o_data is driven from a mux registered on the output (word register). There is no combinational
//    path from i_mat/i_vec to o_data.
// TESTING
//  - Reset, then i_frame_end with i_mat slice k=k+1, i_vec slice k=100+k, i_ready=1 ->
//    o_valid from the next cycle for 27 consecutive cycles; o_data 1..21 then 100..105;
//    o_last only on idx 26; then o_valid=0 and o_busy=0.
//  - Same capture, i_ready toggling 1,0,0,1 repeating -> every word is held stable while stalled;
//    exactly 27 handshakes; correct order; no duplicates or skips.
//  - Second i_frame_end (new data 0xFF..) at idx 5 -> o_drop pulses once; the rest of the stream
//    still carries the first snapshot values.
//  - Second i_frame_end on the idx 26 handshake cycle, new data 200+k -> next cycle o_valid=1,
//    o_idx=0, o_data=200; no idle gap; o_drop stays 0.
//  - Assert i_rst at idx 10 with o_valid=1 -> all outputs 0 in the same cycle, asynchronously.
//    After release, no beats until a new i_frame_end; that stream restarts at idx 0.
//  - Change i_mat/i_vec every cycle without i_frame_end while streaming -> o_data is unaffected
//    (shadow isolation).

Source files
------------

// File: rtl/matrix_stream_out.sv
// Snapshot-and-stream stage for the normal-equation accumulator: captures the 21 Hessian
// lower-triangle words plus 6 gradient words on frame end and streams them out over valid/ready.
module matrix_stream_out #(
    parameter int DATA_BW = 64,
    parameter int NUM_MAT = 21,
    parameter int NUM_VEC = 6
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_frame_end,
    input  logic [NUM_MAT*DATA_BW-1:0] i_mat,
    input  logic [NUM_VEC*DATA_BW-1:0] i_vec,
    output logic                       o_valid,
    input  logic                       i_ready,
    output logic [DATA_BW-1:0]         o_data,
    output logic [4:0]                 o_idx,
    output logic                       o_last,
    output logic                       o_busy,
    output logic                       o_drop
);

    localparam int         NUM_WORDS = NUM_MAT + NUM_VEC;
    localparam logic [4:0] LAST_IDX  = 5'(NUM_WORDS - 1);

    typedef enum logic {
        IDLE,
        SEND
    } state_e;

    state_e               state_q, state_d;
    logic [DATA_BW-1:0]   shadow_q [NUM_WORDS];
    logic [DATA_BW-1:0]   data_q, data_d;
    logic [4:0]           idx_q, idx_d;
    logic                 drop_q, drop_d;
    logic                 handshake;
    logic                 lastBeat;
    logic                 capture;

    // A frame end is taken when idle or exactly on the final handshake, which gives a gapless restart.
    assign handshake = (state_q == SEND) && i_ready;
    assign lastBeat  = handshake && (idx_q == LAST_IDX);
    assign capture   = i_frame_end && ((state_q == IDLE) || lastBeat);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (capture) state_d = SEND;
            SEND: if (lastBeat && !capture) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        o_valid = (state_q == SEND);
        o_busy  = (state_q == SEND);
        o_last  = (state_q == SEND) && (idx_q == LAST_IDX);
        o_data  = data_q;
        o_idx   = idx_q;
        o_drop  = drop_q;
    end

    // Word register: word 0 is loaded straight from the capture inputs, later words from the shadow bank.
    always_comb begin
        data_d = data_q;
        idx_d  = idx_q;
        drop_d = i_frame_end && !capture;
        if (capture) begin
            data_d = i_mat[DATA_BW-1:0];
            idx_d  = '0;
        end else if (lastBeat) begin
            data_d = '0;
            idx_d  = '0;
        end else if (handshake) begin
            data_d = shadow_q[idx_q + 5'd1];
            idx_d  = idx_q + 5'd1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            data_q <= '0;
            idx_q  <= '0;
            drop_q <= 1'b0;
        end else begin
            data_q <= data_d;
            idx_q  <= idx_d;
            drop_q <= drop_d;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int k = 0; k < NUM_WORDS; k++) begin
                shadow_q[k] <= '0;
            end
        end else if (capture) begin
            for (int k = 0; k < NUM_MAT; k++) begin
                shadow_q[k] <= i_mat[k*DATA_BW +: DATA_BW];
            end
            for (int k = 0; k < NUM_VEC; k++) begin
                shadow_q[NUM_MAT + k] <= i_vec[k*DATA_BW +: DATA_BW];
            end
        end
    end

endmodule

// File: tb/tb_matrix_stream_out.sv
// Scoreboard bench for matrix_stream_out: a frame-level model queues expected beats,
// a negedge monitor compares every presented word and the status outputs.
module tb_matrix_stream_out;

    localparam int BW = 64;

    logic              i_clk = 1'b0;
    logic              i_rst;
    logic              i_frame_end;
    logic [21*BW-1:0]  i_mat;
    logic [6*BW-1:0]   i_vec;
    logic              i_ready;
    logic              o_valid;
    logic [BW-1:0]     o_data;
    logic [4:0]        o_idx;
    logic              o_last;
    logic              o_busy;
    logic              o_drop;

    typedef struct packed {
        logic [BW-1:0] d;
        logic [4:0]    idx;
        logic          last;
    } beat_t;

    beat_t expq[$];
    int    pending = 0;
    logic  expDrop = 1'b0;
    int    nChecks = 0;
    int    nFails  = 0;

    matrix_stream_out #(.DATA_BW(BW), .NUM_MAT(21), .NUM_VEC(6)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_frame_end(i_frame_end),
        .i_mat(i_mat), .i_vec(i_vec), .o_valid(o_valid), .i_ready(i_ready),
        .o_data(o_data), .o_idx(o_idx), .o_last(o_last), .o_busy(o_busy), .o_drop(o_drop)
    );

    always #5 i_clk = ~i_clk;

    task automatic checkOutput(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: a snapshot is 27 words in index order; a frame end is taken when nothing
    // is outstanding or the final outstanding word is accepted in the same cycle, otherwise dropped.
    always @(posedge i_clk or posedge i_rst) begin
        bit hs;
        bit acc;
        if (i_rst) begin
            pending = 0;
            expq.delete();
            expDrop = 1'b0;
        end else begin
            hs      = (pending > 0) && i_ready;
            acc     = i_frame_end && ((pending == 0) || (pending == 1 && hs));
            expDrop = i_frame_end && !acc;
            if (hs) pending--;
            if (acc) begin
                pending = 27;
                for (int k = 0; k < 21; k++)
                    expq.push_back('{d: i_mat[k*BW +: BW], idx: 5'(k), last: 1'b0});
                for (int k = 0; k < 6; k++)
                    expq.push_back('{d: i_vec[k*BW +: BW], idx: 5'(21 + k), last: (k == 5)});
            end
        end
    end

    always @(negedge i_clk) begin
        if (!i_rst) begin
            checkOutput("valid", 64'(o_valid), 64'(pending != 0));
            checkOutput("busy", 64'(o_busy), 64'(pending != 0));
            checkOutput("drop", 64'(o_drop), 64'(expDrop));
            if (o_valid) begin
                if (expq.size() == 0) begin
                    nChecks++;
                    nFails++;
                    $display("[TB] FAIL unexpected_beat: got idx %0d data %0h expected no beat", o_idx, o_data);
                end else begin
                    checkOutput("data", o_data, expq[0].d);
                    checkOutput("idx", 64'(o_idx), 64'(expq[0].idx));
                    checkOutput("last", 64'(o_last), 64'(expq[0].last));
                    if (i_ready) void'(expq.pop_front());
                end
            end
        end
    end

    task automatic cycle();
        @(posedge i_clk);
        #1;
    endtask

    task automatic setData(input logic [BW-1:0] matBase, input logic [BW-1:0] vecBase);
        for (int k = 0; k < 21; k++) i_mat[k*BW +: BW] = matBase + BW'(k);
        for (int k = 0; k < 6; k++)  i_vec[k*BW +: BW] = vecBase + BW'(k);
    endtask

    task automatic setRandom();
        for (int k = 0; k < 21; k++) i_mat[k*BW +: BW] = {$urandom, $urandom};
        for (int k = 0; k < 6; k++)  i_vec[k*BW +: BW] = {$urandom, $urandom};
    endtask

    task automatic pulseFrame();
        i_frame_end = 1'b1;
        cycle();
        i_frame_end = 1'b0;
    endtask

    // Drives ready per mode (0 always, 1 the 1,0,0,1 pattern, 2 random) and scrambles the capture
    // inputs every cycle until the model has nothing outstanding or the budget runs out.
    task automatic applyStimulus(input int mode, input int budget, input bit randFe);
        int n;
        n = 0;
        while (pending != 0 && n < budget) begin
            case (mode)
                0:       i_ready = 1'b1;
                1:       i_ready = (n % 4 == 0) || (n % 4 == 3);
                default: i_ready = 1'($urandom_range(0, 1));
            endcase
            setRandom();
            i_frame_end = randFe && (n < 200) && ($urandom_range(0, 19) == 0);
            cycle();
            n++;
        end
        i_frame_end = 1'b0;
        i_ready = 1'b1;
        if (pending != 0) begin
            nChecks++;
            nFails++;
            $display("[TB] FAIL drain_timeout: got %0d words outstanding expected 0", pending);
        end
    endtask

    initial begin
        int n;
        i_rst = 1'b1;
        i_frame_end = 1'b0;
        i_ready = 1'b1;
        i_mat = '0;
        i_vec = '0;
        #1;
        checkOutput("rst_valid", 64'(o_valid), 64'd0);
        checkOutput("rst_data", o_data, 64'd0);
        checkOutput("rst_idx", 64'(o_idx), 64'd0);
        checkOutput("rst_last", 64'(o_last), 64'd0);
        checkOutput("rst_busy", 64'(o_busy), 64'd0);
        checkOutput("rst_drop", 64'(o_drop), 64'd0);
        #21;
        i_rst = 1'b0;
        cycle();
        repeat (3) cycle();

        $display("[TB] full-throughput stream");
        setData(64'd1, 64'd100);
        pulseFrame();
        checkOutput("first_data", o_data, 64'd1);
        applyStimulus(0, 100, 1'b0);
        repeat (2) cycle();

        $display("[TB] stalled stream");
        setData(64'd1, 64'd100);
        pulseFrame();
        applyStimulus(1, 300, 1'b0);
        repeat (2) cycle();

        $display("[TB] rejected frame end");
        setData(64'd1, 64'd100);
        pulseFrame();
        repeat (5) cycle();
        setData(64'hFFFF_FFFF_FFFF_FF00, 64'hFFFF_FFFF_FFFF_FFE0);
        pulseFrame();
        checkOutput("drop_pulse", 64'(o_drop), 64'd1);
        cycle();
        checkOutput("drop_clear", 64'(o_drop), 64'd0);
        applyStimulus(0, 100, 1'b0);
        repeat (2) cycle();

        $display("[TB] back-to-back frame on last beat");
        setData(64'd1, 64'd100);
        pulseFrame();
        repeat (26) cycle();
        setData(64'd200, 64'd221);
        pulseFrame();
        checkOutput("b2b_valid", 64'(o_valid), 64'd1);
        checkOutput("b2b_idx", 64'(o_idx), 64'd0);
        checkOutput("b2b_data", o_data, 64'd200);
        checkOutput("b2b_drop", 64'(o_drop), 64'd0);
        applyStimulus(0, 100, 1'b0);
        repeat (2) cycle();

        $display("[TB] reset mid-stream");
        setData(64'd1, 64'd100);
        pulseFrame();
        n = 0;
        while (!(o_valid && o_idx == 5'd10) && n < 60) begin
            cycle();
            n++;
        end
        if (n >= 60) begin
            nChecks++;
            nFails++;
            $display("[TB] FAIL idx10_timeout: got idx %0d expected 10", o_idx);
        end
        #2;
        i_rst = 1'b1;
        #1;
        checkOutput("arst_valid", 64'(o_valid), 64'd0);
        checkOutput("arst_data", o_data, 64'd0);
        checkOutput("arst_idx", 64'(o_idx), 64'd0);
        checkOutput("arst_last", 64'(o_last), 64'd0);
        checkOutput("arst_busy", 64'(o_busy), 64'd0);
        checkOutput("arst_drop", 64'(o_drop), 64'd0);
        #3;
        i_rst = 1'b0;
        repeat (5) cycle();
        setData(64'd1, 64'd100);
        pulseFrame();
        checkOutput("restart_idx", 64'(o_idx), 64'd0);
        applyStimulus(0, 100, 1'b0);
        repeat (2) cycle();

        $display("[TB] randomized frames");
        for (int t = 0; t < 6; t++) begin
            setRandom();
            pulseFrame();
            applyStimulus(2, 1500, 1'b1);
            repeat ($urandom_range(0, 3)) cycle();
        end

        repeat (3) cycle();
        checkOutput("queue_empty", 64'(expq.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
